// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module : pe_pkg
// Brief  : Shared PE constants: datapath widths and writeback source indices.
// Rev    : 1.0  initial release
// ============================================================================
package pe_pkg;

    localparam int PE_DATA_WIDTH = 32;
    localparam int PE_ADDR_WIDTH = 5;
    localparam int PE_NUM_REGS   = 32;
    localparam int PE_NUM_SRC    = 3;

    localparam int SRC_ALU  = 0;
    localparam int SRC_MUL  = 1;
    localparam int SRC_LOAD = 2;

    // Round-robin successor of index idx among n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage : pe_pkg
`default_nettype wire

// File: rtl/pe_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : pe_rr_arbiter
// Brief  : N-way round-robin arbiter with internal pointer; one-hot grant.
// Rev    : 1.0  initial release
// ============================================================================
module pe_rr_arbiter
    import pe_pkg::*;
#(
    parameter int N    = 3,
    parameter int IDXW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req_i,
    input  logic            advance_i,
    output logic [N-1:0]    grant_o,
    output logic [IDXW-1:0] grant_idx_o
);

    logic [IDXW-1:0] rr_ptr_q;
    logic [IDXW-1:0] rr_ptr_d;
    logic            found;
    int              idx;

    // Scan starting at the pointer, wrapping once around the requesters.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = rr_ptr_q;
        found       = 1'b0;
        idx         = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDXW'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_i && found) begin
            rr_ptr_d = IDXW'(rr_next(int'(grant_idx_o), N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule : pe_rr_arbiter
`default_nettype wire

// File: rtl/pe_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : pe_wb_arbiter
// Brief  : Round-robin writeback merge onto the register-file write port,
//          plus busy-register scoreboard for RAW/WAW hazard detection.
// Rev    : 1.0  initial release
// ============================================================================
module pe_wb_arbiter
    import pe_pkg::*;
#(
    parameter int DATA_WIDTH = PE_DATA_WIDTH,
    parameter int ADDR_WIDTH = PE_ADDR_WIDTH,
    parameter int NUM_REGS   = PE_NUM_REGS,
    parameter int NUM_SRC    = PE_NUM_SRC
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] src_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         wr_addr,
    output logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          alloc_en,
    input  logic [ADDR_WIDTH-1:0]         alloc_addr,
    output logic                          alloc_ok,
    input  logic [ADDR_WIDTH-1:0]         chk_addr1,
    input  logic [ADDR_WIDTH-1:0]         chk_addr2,
    output logic                          chk_busy1,
    output logic                          chk_busy2,
    output logic                          err_waw
);

    localparam int IDXW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]    grant;
    logic [IDXW-1:0]       grant_idx;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  wr_en_q,   wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_REGS-1:0]   busy_q,    busy_d;
    logic                  err_waw_q, err_waw_d;

    pe_rr_arbiter #(
        .N    (NUM_SRC),
        .IDXW (IDXW)
    ) u_rr_arbiter (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (src_valid),
        .advance_i   (transfer),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign src_ready = grant;
    assign transfer  = |src_valid;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_addr = src_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // The pending write is visible through the register-file bypass, so a
    // register being written this cycle already counts as free.
    assign chk_busy1 = busy_q[chk_addr1] && !(wr_en_q && (wr_addr_q == chk_addr1));
    assign chk_busy2 = busy_q[chk_addr2] && !(wr_en_q && (wr_addr_q == chk_addr2));
    assign alloc_ok  = (alloc_addr == '0) ||
                       !(busy_q[alloc_addr] && !(wr_en_q && (wr_addr_q == alloc_addr)));

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (transfer) begin
            wr_en_d   = (sel_addr != '0);
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
    end

    // Clear is applied before set so a same-edge allocation wins.
    always_comb begin
        busy_d    = busy_q;
        err_waw_d = err_waw_q;
        if (wr_en_q && busy_q[wr_addr_q]) begin
            busy_d[wr_addr_q] = 1'b0;
        end
        if (alloc_en) begin
            if (alloc_ok) begin
                if (alloc_addr != '0) begin
                    busy_d[alloc_addr] = 1'b1;
                end
            end else begin
                err_waw_d = 1'b1;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
            err_waw_q <= 1'b0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            err_waw_q <= err_waw_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err_waw = err_waw_q;

endmodule : pe_wb_arbiter
`default_nettype wire

// File: tb/tb_pe_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_pe_wb_arbiter
// Brief  : Directed self-checking bench for pe_wb_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pe_wb_arbiter;
    import pe_pkg::*;

    localparam int DW = PE_DATA_WIDTH;
    localparam int AW = PE_ADDR_WIDTH;
    localparam int NS = PE_NUM_SRC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NS-1:0]    src_valid = '0;
    logic [NS-1:0]    src_ready;
    logic [NS*AW-1:0] src_addr = '0;
    logic [NS*DW-1:0] src_data = '0;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic             alloc_en = 1'b0;
    logic [AW-1:0]    alloc_addr = '0;
    logic             alloc_ok;
    logic [AW-1:0]    chk_addr1 = '0;
    logic [AW-1:0]    chk_addr2 = '0;
    logic             chk_busy1;
    logic             chk_busy2;
    logic             err_waw;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] fair_data [NS];
    logic [NS-1:0] exp_gnt;

    always #5 clk = ~clk;

    pe_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .alloc_ok   (alloc_ok),
        .chk_addr1  (chk_addr1),
        .chk_addr2  (chk_addr2),
        .chk_busy1  (chk_busy1),
        .chk_busy2  (chk_busy2),
        .err_waw    (err_waw)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_valid[i]         = v;
        src_addr[i*AW +: AW] = a;
        src_data[i*DW +: DW] = d;
    endtask

    // Advance past the next rising edge; registered outputs are then stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        fair_data[0] = 32'hA0A0_0000;
        fair_data[1] = 32'hB1B1_1111;
        fair_data[2] = 32'hC2C2_2222;

        // Reset state
        #12;
        check("rst_wr_en",   32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_ready",   32'(src_ready), 32'd0);
        check("rst_alloc_ok", 32'(alloc_ok), 32'd1);
        check("rst_busy1",   32'(chk_busy1), 32'd0);
        check("rst_busy2",   32'(chk_busy2), 32'd0);
        check("rst_err_waw", 32'(err_waw), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fairness: all sources continuously valid
        for (int i = 0; i < NS; i++) set_src(i, 1'b1, AW'(i + 1), fair_data[i]);
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_gnt = NS'(1 << (c % NS));
            check("rr_grant", 32'(src_ready), 32'(exp_gnt));
            tick();
            check("rr_wr_data", wr_data, fair_data[c % NS]);
            check("rr_wr_addr", 32'(wr_addr), 32'((c % NS) + 1));
        end
        for (int i = 0; i < NS; i++) set_src(i, 1'b0, '0, '0);
        tick();
        check("idle_wr_en", 32'(wr_en), 32'd0);

        // Single write from ALU
        set_src(SRC_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("single_ready", 32'(src_ready), 32'b001);
        tick();
        set_src(SRC_ALU, 1'b0, '0, '0);
        check("single_wr_en",   32'(wr_en), 32'd1);
        check("single_wr_addr", 32'(wr_addr), 32'd5);
        check("single_wr_data", wr_data, 32'hDEADBEEF);

        // r0 discard from MUL
        chk_addr1 = 5'd5;
        set_src(SRC_MUL, 1'b1, 5'd0, 32'h5555_5555);
        #1;
        check("r0_ready", 32'(src_ready), 32'b010);
        tick();
        set_src(SRC_MUL, 1'b0, '0, '0);
        check("r0_wr_en", 32'(wr_en), 32'd0);
        check("r0_busy_unch", 32'(chk_busy1), 32'd0);

        // Scoreboard RAW on r7
        alloc_en = 1'b1; alloc_addr = 5'd7;
        #1;
        check("raw_alloc_ok_free", 32'(alloc_ok), 32'd1);
        tick();
        alloc_en = 1'b0; chk_addr1 = 5'd7;
        #1;
        check("raw_busy_set", 32'(chk_busy1), 32'd1);
        check("raw_alloc_ok_busy", 32'(alloc_ok), 32'd0);
        set_src(SRC_LOAD, 1'b1, 5'd7, 32'h0000_0077);
        #1;
        check("raw_load_ready", 32'(src_ready), 32'b100);
        tick();
        set_src(SRC_LOAD, 1'b0, '0, '0);
        #1;
        check("raw_wb_wr_en", 32'(wr_en), 32'd1);
        check("raw_wb_addr", 32'(wr_addr), 32'd7);
        check("raw_bypass_busy", 32'(chk_busy1), 32'd0);
        check("raw_bypass_alloc_ok", 32'(alloc_ok), 32'd1);
        tick();
        check("raw_cleared", 32'(chk_busy1), 32'd0);
        check("raw_idle_wr_en", 32'(wr_en), 32'd0);

        // WAW error on r9
        chk_addr2 = 5'd9;
        alloc_en = 1'b1; alloc_addr = 5'd9;
        tick();
        #1;
        check("waw_second_ok", 32'(alloc_ok), 32'd0);
        check("waw_no_err_yet", 32'(err_waw), 32'd0);
        tick();
        alloc_en = 1'b0;
        check("waw_err_set", 32'(err_waw), 32'd1);
        check("waw_still_busy", 32'(chk_busy2), 32'd1);
        tick();
        check("waw_err_sticky", 32'(err_waw), 32'd1);

        // Same-edge writeback and re-allocation of r9: set wins
        set_src(SRC_ALU, 1'b1, 5'd9, 32'h0000_0099);
        #1;
        check("same_ready", 32'(src_ready), 32'b001);
        tick();
        set_src(SRC_ALU, 1'b0, '0, '0);
        alloc_en = 1'b1; alloc_addr = 5'd9;
        #1;
        check("same_wr_en", 32'(wr_en), 32'd1);
        check("same_alloc_ok", 32'(alloc_ok), 32'd1);
        tick();
        alloc_en = 1'b0;
        #1;
        check("same_busy_kept", 32'(chk_busy2), 32'd1);
        check("same_err_sticky", 32'(err_waw), 32'd1);

        // Async reset mid-stream; pointer sits away from 0 beforehand
        for (int i = 0; i < NS; i++) set_src(i, 1'b1, AW'(i + 1), fair_data[i]);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_wr_en", 32'(wr_en), 32'd0);
        check("arst_busy", 32'(chk_busy2), 32'd0);
        check("arst_err_waw", 32'(err_waw), 32'd0);
        check("arst_ready", 32'(src_ready), 32'b001);
        #10;
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(src_ready), 32'b001);
        tick();
        check("post_rst_wr_data", wr_data, fair_data[SRC_ALU]);
        check("post_rst_wr_en", 32'(wr_en), 32'd1);
        for (int i = 0; i < NS; i++) set_src(i, 1'b0, '0, '0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pe_wb_arbiter
`default_nettype wire
